// File: rtl/bram_fifo_pkg.sv
// Shared constants and types for the block-RAM FIFO controller (2048x8 RAM macro).
package bram_fifo_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    typedef logic [ADDR_W:0] ptr_t;
    typedef logic [ADDR_W:0] level_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order output buffer that absorbs RAM read data and presents it
// on a valid/ready interface; the head entry is always driven on data.
module fifo_skid_buf
    import bram_fifo_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_p2;
    logic [WIDTH-1:0] tail_p2;
    logic [1:0]       cnt_p2;
    logic             pop;

    assign valid = (cnt_p2 != 2'd0);
    assign pop   = valid & ready;
    assign data  = head_p2;
    assign count = cnt_p2;

    // Capture stage: RAM data lands here one cycle after the read issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p2  <= 2'd0;
            head_p2 <= '0;
            tail_p2 <= '0;
        end else begin
            case (cnt_p2)
                2'd0: begin
                    if (push) begin
                        head_p2 <= push_data;
                        cnt_p2  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_p2 <= push_data;
                    end else if (push) begin
                        tail_p2 <= push_data;
                        cnt_p2  <= 2'd2;
                    end else if (pop) begin
                        cnt_p2  <= 2'd0;
                    end
                end
                default: begin
                    // The issue logic never lets a capture arrive at a full buffer
                    // unless the head leaves on the same edge.
                    if (pop) begin
                        head_p2 <= tail_p2;
                        if (push) begin
                            tail_p2 <= push_data;
                        end else begin
                            cnt_p2 <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Streaming FIFO controller driving both ports of the 2048x8 dual-port RAM.
// Define FIFO_LEVEL_FLAGS_EN to add registered ALMOST_FULL / ALMOST_EMPTY outputs.
module bram_fifo_ctrl
    import bram_fifo_pkg::*;
#(
    parameter int ADDR_W = bram_fifo_pkg::ADDR_W,
    parameter int DATA_W = bram_fifo_pkg::DATA_W
`ifdef FIFO_LEVEL_FLAGS_EN
    ,
    parameter int ALMOST_FULL_TH  = 2040,
    parameter int ALMOST_EMPTY_TH = 4
`endif
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [ADDR_W:0]   LEVEL,
    output logic [ADDR_W-1:0] BRAM_A0,
    output logic [DATA_W-1:0] BRAM_D0,
    output logic              BRAM_WE0,
    output logic              BRAM_CE0,
    output logic [DATA_W-1:0] BRAM_WEM0,
    output logic [ADDR_W-1:0] BRAM_A1,
    output logic              BRAM_CE1,
    output logic              BRAM_WE1,
    output logic [DATA_W-1:0] BRAM_D1,
    output logic [DATA_W-1:0] BRAM_WEM1,
    input  logic [DATA_W-1:0] BRAM_Q1
`ifdef FIFO_LEVEL_FLAGS_EN
    ,
    output logic              ALMOST_FULL,
    output logic              ALMOST_EMPTY
`endif
);

    ptr_t       wptr;
    ptr_t       rptr;
    ptr_t       ram_cnt;
    logic       inflight_p1;
    logic [1:0] skid_cnt;
    logic       push;
    logic       pop;
    logic       issue;
    logic [2:0] out_load;
    level_t     level_q;
    level_t     level_nxt;

    assign ram_cnt  = wptr - rptr;
    assign IN_READY = (ram_cnt != ptr_t'(DEPTH));
    assign push     = IN_VALID & IN_READY;
    assign pop      = OUT_VALID & OUT_READY;

    // Words already committed to the output side after this edge; keep it below
    // two so a capture never overruns the skid buffer.
    assign out_load = {1'b0, skid_cnt} + {2'b00, inflight_p1} - {2'b00, pop};
    assign issue    = (ram_cnt != '0) && (out_load < 3'd2);

    // Every word is counted once from acceptance to departure, wherever it sits.
    assign level_nxt = level_q + level_t'(push) - level_t'(pop);

    assign BRAM_A0   = wptr[ADDR_W-1:0];
    assign BRAM_D0   = IN_DATA;
    assign BRAM_WE0  = push;
    assign BRAM_CE0  = push;
    assign BRAM_WEM0 = '1;
    assign BRAM_A1   = rptr[ADDR_W-1:0];
    assign BRAM_CE1  = issue;
    assign BRAM_WE1  = 1'b0;
    assign BRAM_D1   = '0;
    assign BRAM_WEM1 = '0;
    assign LEVEL     = level_q;

    // Issue stage: pointers advance on the write and read-issue edges.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wptr        <= '0;
            rptr        <= '0;
            inflight_p1 <= 1'b0;
            level_q     <= '0;
        end else begin
            wptr        <= wptr + ptr_t'(push);
            rptr        <= rptr + ptr_t'(issue);
            inflight_p1 <= issue;
            level_q     <= level_nxt;
        end
    end

`ifdef FIFO_LEVEL_FLAGS_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ALMOST_FULL  <= 1'b0;
            ALMOST_EMPTY <= 1'b1;
        end else begin
            ALMOST_FULL  <= (level_nxt >= level_t'(ALMOST_FULL_TH));
            ALMOST_EMPTY <= (level_nxt <= level_t'(ALMOST_EMPTY_TH));
        end
    end
`endif

    fifo_skid_buf #(
        .WIDTH (DATA_W)
    ) u_skid (
        .clk       (CLK),
        .rst_n     (RST_N),
        .push      (inflight_p1),
        .push_data (BRAM_Q1),
        .valid     (OUT_VALID),
        .ready     (OUT_READY),
        .data      (OUT_DATA),
        .count     (skid_cnt)
    );

endmodule
